// File: rtl/seg_scan_controller.sv
// Four-digit seven-segment scan scheduler: slot timing, dead time, PWM window,
// per-frame input snapshot and registered anode / decimal-point / hex drive.
module seg_scan_controller #(
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] num0,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic [3:0] dp_in,
  input  logic [3:0] digit_en,
  input  logic [3:0] brightness,
  output logic [3:0] hex_out,
  output logic [3:0] an,
  output logic       dp_n,
  output logic [1:0] digit_sel,
  output logic       frame_done
);

  typedef enum logic [1:0] {OFF, BLANK, ON, TAIL} state_t;

  localparam int unsigned PW   = CNT_W + 5;
  localparam int unsigned SPAN = PRESCALE - BLANK_CYCLES;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYCLES);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [1:0]        sel_nxt;
  logic [CNT_W-1:0]  win, win_nxt, win_calc;
  logic [PW-1:0]     win_prod;
  logic [3:0][3:0]   snap_num, num_nxt;
  logic [3:0]        snap_dp, dp_nxt_snap;
  logic [3:0]        snap_den, den_nxt;
  logic              capture, fd_nxt, lit;
  logic [3:0]        an_nxt, hex_nxt;
  logic              dp_n_nxt;

  // ON-window length for the brightness presented this cycle
  always_comb begin
    win_prod = PW'(SPAN) * PW'(5'({1'b0, brightness}) + 5'd1);
    win_calc = CNT_W'(win_prod >> 4);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = digit_sel;
    win_nxt   = win;
    capture   = 1'b0;
    fd_nxt    = 1'b0;
    if (!en) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
      sel_nxt   = '0;
    end else if (state == OFF) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
      sel_nxt   = '0;
      capture   = 1'b1;
    end else if (cnt == LAST) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
      sel_nxt   = digit_sel + 2'd1;
      if (digit_sel == 2'd3) begin
        capture = 1'b1;
        fd_nxt  = 1'b1;
      end
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
      case (state)
        BLANK: if (cnt == BLANK_LAST) begin
          win_nxt   = win_calc;
          state_nxt = (win_calc == '0) ? TAIL : ON;
        end
        ON: if (cnt_nxt == BLANK_END + win) state_nxt = TAIL;
        default: ;
      endcase
    end

    num_nxt     = capture ? {num3, num2, num1, num0} : snap_num;
    dp_nxt_snap = capture ? dp_in : snap_dp;
    den_nxt     = capture ? digit_en : snap_den;

    // Outputs are derived from next-state values so they line up with cnt/state
    lit      = (state_nxt == ON) && den_nxt[sel_nxt];
    an_nxt   = 4'hF;
    if (lit) an_nxt[sel_nxt] = 1'b0;
    dp_n_nxt = ~(lit & dp_nxt_snap[sel_nxt]);
    hex_nxt  = hex_out;
    if (state_nxt == BLANK && cnt_nxt == '0) hex_nxt = num_nxt[sel_nxt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= OFF;
      cnt        <= '0;
      digit_sel  <= '0;
      win        <= '0;
      snap_num   <= '0;
      snap_dp    <= '0;
      snap_den   <= '0;
      an         <= 4'hF;
      dp_n       <= 1'b1;
      hex_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digit_sel  <= sel_nxt;
      win        <= win_nxt;
      snap_num   <= num_nxt;
      snap_dp    <= dp_nxt_snap;
      snap_den   <= den_nxt;
      an         <= an_nxt;
      dp_n       <= dp_n_nxt;
      hex_out    <= hex_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
Time-multiplexing scheduler for the four-digit seven-segment display.
- Steps through the four digits at a programmable slot rate.
- Inserts anti-ghosting dead time between digits and applies PWM brightness.
- Latches a tear-free snapshot of the digit values once per frame.
- Drives a downstream hex-to-7-segment decoder through hex_out, and the board anode and decimal-point pins directly.

Parameters:
PRESCALE, 1000, clk cycles per digit slot (>= BLANK_CYCLES+2)
BLANK_CYCLES, 8, dead-time cycles at start of each slot, all anodes off
CNT_W, 16, width of slot cycle counter (2^CNT_W > PRESCALE)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  scan enable; 0 blanks display
num0  in  4  digit 0 value (rightmost)
num1  in  4  digit 1 value
num2  in  4  digit 2 value
num3  in  4  digit 3 value (leftmost)
dp_in  in  4  per-digit decimal point request, bit i = digit i, 1 = lit
digit_en  in  4  per-digit enable, bit i = digit i; 0 = digit forced dark
brightness  in  4  duty level, 0 = dark, 15 = full
hex_out  out  4  nibble for the 7-seg decoder (snapshot of active digit)
an  out  4  anodes, active low, an[i] = digit i
dp_n  out  1  decimal point, active low
digit_sel  out  2  index of current slot
frame_done  out  1  one-cycle pulse at end of digit-3 slot

Behaviour:
- Reset (async assert, sync release): state OFF, an=4'b1111, dp_n=1, hex_out=0, digit_sel=0, frame_done=0, cnt=0, snapshot regs=0.
- All outputs registered; no combinational path from inputs to outputs.
- FSM states:
  - OFF: an all 1; go to BLANK with digit_sel=0 and cnt=0 when en=1.
  - BLANK: cnt < BLANK_CYCLES.
  - ON: anode window active.
  - TAIL: rest of slot after the window.
- Slot timing: cnt counts 0..PRESCALE-1, then wraps to 0 and digit_sel increments mod 4 (3 -> 0).
- ON window: W = ((PRESCALE-BLANK_CYCLES)*(brightness+1))>>4 cycles, integer floor. ON holds for BLANK_CYCLES <= cnt < BLANK_CYCLES+W, then TAIL.
  - W=0: ON is skipped entirely and the slot goes BLANK -> TAIL.
  - brightness is sampled once, at cnt==BLANK_CYCLES-1, and is held for the slot.
- an[digit_sel]=0 only in ON, and only if snapshot digit_en bit is 1; otherwise an=4'b1111.
- dp_n=0 only when the anode is lit and the snapshot dp bit is 1.
- hex_out = snapshot num[digit_sel], updated on the cycle the slot starts (cnt==0), so it is stable throughout the BLANK phase.
- Snapshot: num0..3, dp_in and digit_en are captured on the clock where digit_sel becomes 0 with cnt==0. This happens at entry from OFF and at every frame wrap. Input changes mid-frame take effect only at the next frame.
- frame_done=1 for exactly one cycle: the cycle after cnt==PRESCALE-1 with digit_sel==3. It coincides with the new snapshot.
- en deassert: at any point, on the next clock go to OFF; an=4'b1111 and dp_n=1 on that edge. cnt and digit_sel are cleared, and no frame_done is issued.
- en reassert: always restarts at digit 0 with a fresh snapshot.
- reset mid-slot: outputs reach reset values immediately, asynchronously.
- Invariant: at most one an bit is 0 in any cycle. Across any slot boundary, at least BLANK_CYCLES cycles have all anodes off.

Test Plan:
All scenarios use PRESCALE=16, BLANK_CYCLES=2.
1. Reset with en=1, num0..3=1,2,3,4, digit_en=F, brightness=15:
   - During reset: an=1111, dp_n=1.
   - After release: an=1110 on cnt 2..15 with hex_out=1, then an=1101 with hex_out=2, and so on through digit 3.
   - frame_done pulses every 64 cycles.
2. brightness=7: W=7, so each digit is lit on cnt 2..8 and dark on 9..15. brightness=0: an stays 1111 for the whole frame, while digit_sel still advances.
3. Change num1 from 2 to 9 while digit_sel=0:
   - hex_out for slot 1 remains 2 in the current frame.
   - Shows 9 after the next frame_done.
4. digit_en=4'b0101, dp_in=4'b0001:
   - Digits 1 and 3 never light.
   - dp_n=0 only while an=1110 is active.
5. Drop en during the ON phase of digit 2:
   - The next edge gives an=1111 and dp_n=1.
   - Re-raise en: restart at digit 0, cnt 0; no spurious frame_done.
6. Assert reset asynchronously mid-ON, between clock edges: an returns to 1111 immediately. Randomised run: assert at most one an bit low per cycle and a >=2-cycle all-off gap at every slot change.
